axi_lite_master: RTL and testbench

- Initiator end of the AXI-Lite register link: turns single-beat user read/write commands into AXI-Lite transactions and returns data and response to the user.
- Sits in front of any AXI-Lite slave (e.g. the team's register-access slave) in test harnesses and CPU-less control paths.
- One transaction in flight at a time.
- A per-transaction watchdog catches slaves that never respond.

---
 rtl/axi_lite_master.sv | 211 +++++++++++++++++++++
 tb/tb_axi_lite_master.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master.sv
// AXI-Lite initiator: turns single-beat user read/write commands into AXI-Lite
// transactions, with a per-transaction watchdog that latches the block in HALT.
module axi_lite_master #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int STROBE_WIDTH   = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_cmd_stb,
  input  logic                    i_cmd_wr,
  input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [DATA_WIDTH-1:0]   i_cmd_data,
  output logic                    o_cmd_rdy,
  output logic                    o_cmd_done_stb,
  output logic [DATA_WIDTH-1:0]   o_cmd_rd_data,
  output logic [1:0]              o_cmd_resp,
  output logic                    o_cmd_timeout,
  output logic                    o_awvalid,
  output logic [ADDR_WIDTH-1:0]   o_awaddr,
  input  logic                    i_awready,
  output logic                    o_wvalid,
  output logic [DATA_WIDTH-1:0]   o_wdata,
  output logic [STROBE_WIDTH-1:0] o_wstrb,
  input  logic                    i_wready,
  input  logic                    i_bvalid,
  output logic                    o_bready,
  input  logic [1:0]              i_bresp,
  output logic                    o_arvalid,
  output logic [ADDR_WIDTH-1:0]   o_araddr,
  input  logic                    i_arready,
  input  logic                    i_rvalid,
  output logic                    o_rready,
  input  logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic [1:0]              i_rresp
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE, HALT
  } state_t;

  state_t                  state_reg, state_next;
  logic                    rdy_reg, rdy_next;
  logic                    done_reg, done_next;
  logic                    timeout_reg, timeout_next;
  logic                    awvalid_reg, awvalid_next;
  logic                    wvalid_reg, wvalid_next;
  logic                    bready_reg, bready_next;
  logic                    arvalid_reg, arvalid_next;
  logic                    rready_reg, rready_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
  logic [STROBE_WIDTH-1:0] wstrb_reg, wstrb_next;
  logic [DATA_WIDTH-1:0]   rd_data_reg, rd_data_next;
  logic [1:0]              resp_reg, resp_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;

  logic accept, active, wd_fire;

  assign accept  = i_cmd_stb & rdy_reg;
  assign active  = (state_reg == WR_ADDR_DATA) || (state_reg == WR_RESP) ||
                   (state_reg == RD_ADDR) || (state_reg == RD_DATA);
  assign wd_fire = (TIMEOUT_CYCLES != 0) && active && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      rdy_reg     <= 1'b0;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      bready_reg  <= 1'b0;
      arvalid_reg <= 1'b0;
      rready_reg  <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      rd_data_reg <= '0;
      resp_reg    <= 2'b00;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      rdy_reg     <= rdy_next;
      done_reg    <= done_next;
      timeout_reg <= timeout_next;
      awvalid_reg <= awvalid_next;
      wvalid_reg  <= wvalid_next;
      bready_reg  <= bready_next;
      arvalid_reg <= arvalid_next;
      rready_reg  <= rready_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      wstrb_reg   <= wstrb_next;
      rd_data_reg <= rd_data_next;
      resp_reg    <= resp_next;
      cnt_reg     <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    rdy_next     = rdy_reg;
    done_next    = 1'b0;
    timeout_next = timeout_reg;
    awvalid_next = awvalid_reg;
    wvalid_next  = wvalid_reg;
    bready_next  = bready_reg;
    arvalid_next = arvalid_reg;
    rready_next  = rready_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    wstrb_next   = wstrb_reg;
    rd_data_next = rd_data_reg;
    resp_next    = resp_reg;
    cnt_next     = active && (cnt_reg != '1) ? cnt_reg + CNT_W'(1) : cnt_reg;

    case (state_reg)
      // DONE accepts like IDLE so a held strobe issues back-to-back commands
      IDLE, DONE: begin
        state_next = IDLE;
        rdy_next   = 1'b1;
        if (accept) begin
          rdy_next   = 1'b0;
          cnt_next   = '0;
          addr_next  = i_cmd_addr;
          wdata_next = i_cmd_data;
          if (i_cmd_wr) begin
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
            wstrb_next   = '1;
            state_next   = WR_ADDR_DATA;
          end else begin
            arvalid_next = 1'b1;
            state_next   = RD_ADDR;
          end
        end
      end
      WR_ADDR_DATA: begin
        awvalid_next = awvalid_reg & ~i_awready;
        wvalid_next  = wvalid_reg & ~i_wready;
        if (!awvalid_next && !wvalid_next) begin
          bready_next = 1'b1;
          state_next  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (i_bvalid && bready_reg) begin
          resp_next   = i_bresp;
          bready_next = 1'b0;
          done_next   = 1'b1;
          rdy_next    = 1'b1;
          state_next  = DONE;
        end
      end
      RD_ADDR: begin
        if (i_arready) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          state_next   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (i_rvalid && rready_reg) begin
          rd_data_next = i_rdata;
          resp_next    = i_rresp;
          rready_next  = 1'b0;
          done_next    = 1'b1;
          rdy_next     = 1'b1;
          state_next   = DONE;
        end
      end
      HALT: rdy_next = 1'b0;
      default: state_next = IDLE;
    endcase

    // Watchdog expiry overrides any progress made in the same cycle
    if (wd_fire) begin
      state_next   = HALT;
      awvalid_next = 1'b0;
      wvalid_next  = 1'b0;
      bready_next  = 1'b0;
      arvalid_next = 1'b0;
      rready_next  = 1'b0;
      rdy_next     = 1'b0;
      done_next    = 1'b1;
      resp_next    = 2'b10;
      timeout_next = 1'b1;
    end
  end

  assign o_cmd_rdy      = rdy_reg;
  assign o_cmd_done_stb = done_reg;
  assign o_cmd_rd_data  = rd_data_reg;
  assign o_cmd_resp     = resp_reg;
  assign o_cmd_timeout  = timeout_reg;
  assign o_awvalid      = awvalid_reg;
  assign o_awaddr       = addr_reg;
  assign o_wvalid       = wvalid_reg;
  assign o_wdata        = wdata_reg;
  assign o_wstrb        = wstrb_reg;
  assign o_bready       = bready_reg;
  assign o_arvalid      = arvalid_reg;
  assign o_araddr       = addr_reg;
  assign o_rready       = rready_reg;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: a transaction-level reference model is
// compared against every output each cycle, plus literal checks per scenario.
module tb_axi_lite_master;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_cmd_stb = 1'b0, i_cmd_wr = 1'b0;
  logic [15:0] i_cmd_addr = '0;
  logic [31:0] i_cmd_data = '0;
  logic        o_cmd_rdy, o_cmd_done_stb, o_cmd_timeout;
  logic [31:0] o_cmd_rd_data;
  logic [1:0]  o_cmd_resp;
  logic        o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready;
  logic [15:0] o_awaddr, o_araddr;
  logic [31:0] o_wdata;
  logic [3:0]  o_wstrb;
  logic        i_awready = 1'b0, i_wready = 1'b0, i_bvalid = 1'b0;
  logic        i_arready = 1'b0, i_rvalid = 1'b0;
  logic [1:0]  i_bresp = 2'b00, i_rresp = 2'b00;
  logic [31:0] i_rdata = '0;

  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  axi_lite_master #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .STROBE_WIDTH(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_stb(i_cmd_stb), .i_cmd_wr(i_cmd_wr), .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data),
    .o_cmd_rdy(o_cmd_rdy), .o_cmd_done_stb(o_cmd_done_stb), .o_cmd_rd_data(o_cmd_rd_data),
    .o_cmd_resp(o_cmd_resp), .o_cmd_timeout(o_cmd_timeout),
    .o_awvalid(o_awvalid), .o_awaddr(o_awaddr), .i_awready(i_awready),
    .o_wvalid(o_wvalid), .o_wdata(o_wdata), .o_wstrb(o_wstrb), .i_wready(i_wready),
    .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
    .o_arvalid(o_arvalid), .o_araddr(o_araddr), .i_arready(i_arready),
    .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rdata(i_rdata), .i_rresp(i_rresp)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding command, tracked as pending channel handshakes
  logic        m_busy, m_rdy, m_done, m_timeout, m_halt;
  logic        m_aw, m_w, m_b, m_ar, m_r;
  logic [15:0] m_addr;
  logic [31:0] m_wdata, m_rd_data;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_resp;
  int          m_age;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_rdy <= 1'b0; m_done <= 1'b0; m_timeout <= 1'b0; m_halt <= 1'b0;
      m_aw <= 1'b0; m_w <= 1'b0; m_b <= 1'b0; m_ar <= 1'b0; m_r <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_rd_data <= '0; m_wstrb <= '0; m_resp <= '0; m_age <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_halt) begin
        m_rdy <= 1'b0;
      end else if (!m_busy) begin
        m_rdy <= 1'b1;
        if (i_cmd_stb && m_rdy) begin
          m_rdy <= 1'b0; m_busy <= 1'b1; m_age <= 0;
          m_addr <= i_cmd_addr; m_wdata <= i_cmd_data;
          if (i_cmd_wr) begin
            m_aw <= 1'b1; m_w <= 1'b1; m_wstrb <= 4'hF;
          end else begin
            m_ar <= 1'b1;
          end
        end
      end else if (m_age + 1 == TMO) begin
        m_halt <= 1'b1; m_busy <= 1'b0; m_rdy <= 1'b0;
        m_aw <= 1'b0; m_w <= 1'b0; m_b <= 1'b0; m_ar <= 1'b0; m_r <= 1'b0;
        m_done <= 1'b1; m_resp <= 2'b10; m_timeout <= 1'b1;
      end else begin
        m_age <= m_age + 1;
        if (m_aw && i_awready) m_aw <= 1'b0;
        if (m_w && i_wready) m_w <= 1'b0;
        if ((m_aw || m_w) && (!m_aw || i_awready) && (!m_w || i_wready)) m_b <= 1'b1;
        if (m_b && i_bvalid) begin
          m_b <= 1'b0; m_resp <= i_bresp; m_busy <= 1'b0; m_done <= 1'b1; m_rdy <= 1'b1;
        end
        if (m_ar && i_arready) begin
          m_ar <= 1'b0; m_r <= 1'b1;
        end
        if (m_r && i_rvalid) begin
          m_r <= 1'b0; m_rd_data <= i_rdata; m_resp <= i_rresp;
          m_busy <= 1'b0; m_done <= 1'b1; m_rdy <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmd_rdy",  32'(o_cmd_rdy),      32'(m_rdy));
      check("done_stb", 32'(o_cmd_done_stb), 32'(m_done));
      check("rd_data",  o_cmd_rd_data,       m_rd_data);
      check("resp",     32'(o_cmd_resp),     32'(m_resp));
      check("timeout",  32'(o_cmd_timeout),  32'(m_timeout));
      check("awvalid",  32'(o_awvalid),      32'(m_aw));
      check("awaddr",   32'(o_awaddr),       32'(m_addr));
      check("wvalid",   32'(o_wvalid),       32'(m_w));
      check("wdata",    o_wdata,             m_wdata);
      check("wstrb",    32'(o_wstrb),        32'(m_wstrb));
      check("bready",   32'(o_bready),       32'(m_b));
      check("arvalid",  32'(o_arvalid),      32'(m_ar));
      check("araddr",   32'(o_araddr),       32'(m_addr));
      check("rready",   32'(o_rready),       32'(m_r));
      if (o_cmd_done_stb === 1'b1)
        $display("txn done: resp=%0d rd_data=%h timeout=%0d t=%0t",
                 o_cmd_resp, o_cmd_rd_data, o_cmd_timeout, $time);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  // Steps until done is seen; lat counts cycles since acceptance
  task automatic wait_done(input int start, input int limit, output int lat);
    lat = start;
    while (o_cmd_done_stb !== 1'b1 && lat < limit) begin
      cyc();
      lat++;
    end
    if (o_cmd_done_stb !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL done_wait: got no done within %0d cycles want done pulse", limit);
    end
  endtask

  task automatic send(input logic wr, input logic [15:0] addr, input logic [31:0] data);
    i_cmd_stb = 1'b1; i_cmd_wr = wr; i_cmd_addr = addr; i_cmd_data = data;
    cyc();
    i_cmd_stb = 1'b0;
  endtask

  int lat;

  initial begin
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    #1 check("rst_rdy", 32'(o_cmd_rdy), 32'h0);
    repeat (2) cyc();
    rst_n = 1'b1;
    #1 check("rdy_before_edge", 32'(o_cmd_rdy), 32'h0);
    cyc();
    check("rdy_after_edge", 32'(o_cmd_rdy), 32'h1);

    // Zero-wait write
    i_awready = 1'b1; i_wready = 1'b1; i_bvalid = 1'b1; i_arready = 1'b1; i_rvalid = 1'b1;
    i_bresp = 2'b00;
    send(1'b1, 16'h0010, 32'hDEADBEEF);
    check("w1_awvalid", 32'(o_awvalid), 32'h1);
    check("w1_wvalid", 32'(o_wvalid), 32'h1);
    check("w1_wstrb", 32'(o_wstrb), 32'hF);
    check("w1_awaddr", 32'(o_awaddr), 32'h0010);
    check("w1_wdata", o_wdata, 32'hDEADBEEF);
    cyc();
    check("w1_bready", 32'(o_bready), 32'h1);
    cyc();
    check("w1_done", 32'(o_cmd_done_stb), 32'h1);
    check("w1_resp", 32'(o_cmd_resp), 32'h0);
    cyc();
    check("w1_done_once", 32'(o_cmd_done_stb), 32'h0);

    // Read with 5-cycle arready delay, DECERR
    i_arready = 1'b0; i_rdata = 32'h12345678; i_rresp = 2'b11;
    send(1'b0, 16'h0020, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      check("r2_arvalid_held", 32'(o_arvalid), 32'h1);
      check("r2_araddr", 32'(o_araddr), 32'h0020);
      if (k == 5) i_arready = 1'b1;
      cyc();
    end
    check("r2_rready", 32'(o_rready), 32'h1);
    cyc();
    check("r2_done", 32'(o_cmd_done_stb), 32'h1);
    check("r2_rd_data", o_cmd_rd_data, 32'h12345678);
    check("r2_resp", 32'(o_cmd_resp), 32'h3);
    check("model_rd_data", m_rd_data, 32'h12345678);
    check("model_resp", 32'(m_resp), 32'h3);
    cyc();

    // Write with W handshake three cycles ahead of AW, SLVERR
    i_awready = 1'b0; i_wready = 1'b1; i_bresp = 2'b10;
    send(1'b1, 16'h0050, 32'hA5A55A5A);
    check("w3_both_valid", 32'({o_awvalid, o_wvalid}), 32'h3);
    cyc();
    check("w3_wvalid_drop", 32'(o_wvalid), 32'h0);
    check("w3_awvalid_hold", 32'(o_awvalid), 32'h1);
    cyc();
    cyc();
    check("w3_awvalid_n4", 32'(o_awvalid), 32'h1);
    i_awready = 1'b1;
    wait_done(4, 20, lat);
    check("w3_latency", 32'(lat), 32'd6);
    check("w3_resp", 32'(o_cmd_resp), 32'h2);
    check("w3_rd_data_kept", o_cmd_rd_data, 32'h12345678);
    cyc();
    check("w3_done_once", 32'(o_cmd_done_stb), 32'h0);

    // Back-to-back: read then write with the strobe held high
    i_bresp = 2'b00; i_rresp = 2'b00; i_rdata = 32'hCAFEF00D;
    i_cmd_stb = 1'b1; i_cmd_wr = 1'b0; i_cmd_addr = 16'h0030;
    cyc();
    i_cmd_wr = 1'b1; i_cmd_addr = 16'h0040; i_cmd_data = 32'h11112222;
    check("b2b_arvalid", 32'(o_arvalid), 32'h1);
    cyc();
    cyc();
    check("b2b_done1", 32'(o_cmd_done_stb), 32'h1);
    check("b2b_rd_data1", o_cmd_rd_data, 32'hCAFEF00D);
    check("b2b_rdy_in_done", 32'(o_cmd_rdy), 32'h1);
    i_rdata = 32'h0BADBEEF;
    cyc();
    i_cmd_stb = 1'b0;
    check("b2b_awvalid", 32'(o_awvalid), 32'h1);
    check("b2b_awaddr", 32'(o_awaddr), 32'h0040);
    cyc();
    cyc();
    check("b2b_done2", 32'(o_cmd_done_stb), 32'h1);
    check("b2b_rd_data_kept", o_cmd_rd_data, 32'hCAFEF00D);
    cyc();

    // Asynchronous reset while arvalid is pending
    i_arready = 1'b0;
    send(1'b0, 16'h0060, 32'h0);
    cyc();
    #1 rst_n = 1'b0;
    #1;
    check("ar_rst_arvalid", 32'(o_arvalid), 32'h0);
    check("ar_rst_araddr", 32'(o_araddr), 32'h0);
    check("ar_rst_wstrb", 32'(o_wstrb), 32'h0);
    check("ar_rst_rd_data", o_cmd_rd_data, 32'h0);
    check("ar_rst_rdy", 32'(o_cmd_rdy), 32'h0);
    cyc();
    rst_n = 1'b1;
    #1 check("ar_rel_rdy0", 32'(o_cmd_rdy), 32'h0);
    cyc();
    check("ar_rel_rdy1", 32'(o_cmd_rdy), 32'h1);
    i_arready = 1'b1;

    // Watchdog: slave never answers the write
    i_bvalid = 1'b0;
    send(1'b1, 16'h0070, 32'h55AA55AA);
    wait_done(1, 40, lat);
    check("tmo_latency", 32'(lat), 32'd17);
    check("tmo_resp", 32'(o_cmd_resp), 32'h2);
    check("tmo_flag", 32'(o_cmd_timeout), 32'h1);
    check("tmo_rdy", 32'(o_cmd_rdy), 32'h0);
    check("tmo_bready", 32'(o_bready), 32'h0);
    i_cmd_stb = 1'b1; i_cmd_wr = 1'b0;
    repeat (4) begin
      cyc();
      check("halt_rdy", 32'(o_cmd_rdy), 32'h0);
      check("halt_arvalid", 32'(o_arvalid), 32'h0);
    end
    i_cmd_stb = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("halt_rst_timeout", 32'(o_cmd_timeout), 32'h0);
    check("halt_rst_resp", 32'(o_cmd_resp), 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("halt_rel_rdy", 32'(o_cmd_rdy), 32'h1);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got no finish want finish before 50000");
    $fatal(1);
  end
endmodule
